// File: rtl/bank_mmu_decoder_if.sv
// CPU-side bus bundle for bank_mmu_decoder: address/strobe in, selects, mapped RAM address and ready out.
interface bank_mmu_decoder_if #(
  parameter int unsigned NUM_DEV  = 16,
  parameter int unsigned EXT_BITS = 4
);
  logic                  cyc_i;
  logic                  we_i;
  logic [15:0]           addr_i;
  logic [7:0]            data_i;
  logic [7:0]            data_o;
  logic                  dec_cs_o;
  logic                  rom_cs_o;
  logic                  ram_cs_o;
  logic                  ram_we_o;
  logic [13+EXT_BITS-1:0] ram_addr_o;
  logic [NUM_DEV-1:0]    dev_cs_o;
  logic                  rdy_o;

  modport master (
    output cyc_i, we_i, addr_i, data_i,
    input  data_o, dec_cs_o, rom_cs_o, ram_cs_o, ram_we_o, ram_addr_o, dev_cs_o, rdy_o
  );

  modport slave (
    input  cyc_i, we_i, addr_i, data_i,
    output data_o, dec_cs_o, rom_cs_o, ram_cs_o, ram_we_o, ram_addr_o, dev_cs_o, rdy_o
  );
endinterface

// File: rtl/bank_mmu_decoder.sv
// 6502 address decoder: zero-page control registers, one-hot I/O selects, boot ROM,
// eight-window RAM banking and per-device wait-state stall of the CPU.
module bank_mmu_decoder #(
  parameter int unsigned        NUM_DEV   = 16,
  parameter int unsigned        EXT_BITS  = 4,
  parameter logic [7:0]         IO_PAGE   = 8'hFE,
  parameter logic [7:0]         ROM_PAGE  = 8'hE0,
  parameter int unsigned        WAIT_CYC  = 2,
  parameter logic [NUM_DEV-1:0] WAIT_MASK = NUM_DEV'(16'h0008)
) (
  input logic               clk_i,
  input logic               rst_i,
  bank_mmu_decoder_if.slave bus
);

  localparam int unsigned RA_W  = 13 + EXT_BITS;
  localparam int unsigned CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;

  logic [7:0]          io_bank_l;
  logic [7:0]          io_bank_h;
  logic [7:0]          rom_sel;
  logic [EXT_BITS-1:0] bank [8];

  logic                hit_l, hit_h, hit_rom, hit_bank;
  logic                dec_cs, rom_cs, ram_cs;
  logic [NUM_DEV-1:0]  dev_cs;
  logic [7:0]          rd_data;
  logic                dev_ok;
  logic                waited;
  logic                rdy;
  logic                wr_en;

  // Register address match
  always_comb begin
    hit_l    = (bus.addr_i == 16'h0000);
    hit_h    = (bus.addr_i == 16'h0001);
    hit_rom  = (bus.addr_i == 16'h0002);
    hit_bank = (bus.addr_i[15:3] == 13'h0002);
  end

  assign dev_ok = ({1'b0, io_bank_l} < 9'(NUM_DEV));

  // Priority decode: registers, I/O page, ROM, then RAM
  always_comb begin
    dec_cs  = hit_l | hit_h | hit_rom | hit_bank;
    rom_cs  = 1'b0;
    ram_cs  = 1'b0;
    dev_cs  = '0;
    rd_data = 8'h00;
    if (dec_cs) begin
      if (hit_l)        rd_data = io_bank_l;
      else if (hit_h)   rd_data = io_bank_h;
      else if (hit_rom) rd_data = rom_sel;
      else              rd_data = 8'(bank[bus.addr_i[2:0]]);
    end else if (bus.addr_i[15:8] == IO_PAGE) begin
      if (dev_ok) begin
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
          dev_cs[i] = (io_bank_l == 8'(i));
        end
      end else begin
        ram_cs = 1'b1;
      end
    end else if ((bus.addr_i[15:8] >= ROM_PAGE) && (rom_sel == 8'h00)) begin
      rom_cs = 1'b1;
    end else begin
      ram_cs = 1'b1;
    end
  end

  assign waited = (WAIT_CYC > 0) && (|(dev_cs & WAIT_MASK));

  // Wait-state FSM: rdy drops combinationally on the strobe clock
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdy      = 1'b1;
    case (state)
      IDLE: begin
        if (bus.cyc_i && waited) begin
          rdy = 1'b0;
          if (WAIT_CYC > 1) begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(WAIT_CYC - 1);
          end
        end
      end
      WAIT: begin
        rdy    = 1'b0;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign wr_en = bus.cyc_i & bus.we_i & rdy & dec_cs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      io_bank_l <= 8'h00;
      io_bank_h <= 8'h00;
      rom_sel   <= 8'h00;
      for (int k = 0; k < 8; k++) bank[k] <= EXT_BITS'(k);
    end else if (wr_en) begin
      if (hit_l)    io_bank_l <= bus.data_i;
      if (hit_h)    io_bank_h <= bus.data_i;
      if (hit_rom)  rom_sel   <= bus.data_i;
      if (hit_bank) bank[bus.addr_i[2:0]] <= bus.data_i[EXT_BITS-1:0];
    end
  end

  assign bus.data_o     = rd_data;
  assign bus.dec_cs_o   = dec_cs;
  assign bus.rom_cs_o   = rom_cs;
  assign bus.ram_cs_o   = ram_cs;
  assign bus.ram_we_o   = ram_cs & bus.we_i;
  assign bus.ram_addr_o = RA_W'({bank[bus.addr_i[15:13]], bus.addr_i[12:0]});
  assign bus.dev_cs_o   = dev_cs;
  assign bus.rdy_o      = rdy;

endmodule

// File: tb/tb_bank_mmu_decoder.sv
// Bench for bank_mmu_decoder: vector table plus hand-written wait-state and reset sequences,
// expectations queued at drive time and compared on the falling edge.
module tb_bank_mmu_decoder;

  typedef struct packed {
    logic        dec;
    logic        rom;
    logic        ram;
    logic        ram_we;
    logic [16:0] ra;
    logic [15:0] dev;
    logic        rdy;
    logic [7:0]  dat;
  } exp_t;

  typedef struct {
    logic        cyc;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    exp_t        e;
  } vec_t;

  localparam logic [3:0] DEC  = 4'b1000;
  localparam logic [3:0] ROM  = 4'b0100;
  localparam logic [3:0] RAM  = 4'b0010;
  localparam logic [3:0] RAMW = 4'b0011;
  localparam logic [3:0] DEV  = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_mmu_decoder_if #(.NUM_DEV(16), .EXT_BITS(4)) bus ();

  bank_mmu_decoder #(
    .NUM_DEV(16), .EXT_BITS(4), .IO_PAGE(8'hFE), .ROM_PAGE(8'hE0),
    .WAIT_CYC(2), .WAIT_MASK(16'h0008)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[$];
  int    errors = 0;
  int    checks = 0;
  bit    drain = 1'b0;
  bit    drain_done = 1'b0;

  function automatic exp_t ex(input logic [3:0] sel, input logic [16:0] ra,
                              input logic [15:0] dev, input logic rdy, input logic [7:0] dat);
    exp_t e;
    {e.dec, e.rom, e.ram, e.ram_we} = sel;
    e.ra  = ra;
    e.dev = dev;
    e.rdy = rdy;
    e.dat = dat;
    return e;
  endfunction

  function automatic void add(input logic c, input logic w, input logic [15:0] a,
                              input logic [7:0] d, input exp_t e);
    vec_t v;
    v.cyc = c; v.we = w; v.addr = a; v.data = d; v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic c, input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic r, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    rst        = r;
    bus.cyc_i  = c;
    bus.we_i   = w;
    bus.addr_i = a;
    bus.data_i = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Scoreboard: one expectation per driven clock, checked mid-cycle
  always @(negedge clk) begin
    exp_t  got, want;
    string nm;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {bus.dec_cs_o, bus.rom_cs_o, bus.ram_cs_o, bus.ram_we_o, bus.ram_addr_o,
              bus.dev_cs_o, bus.rdy_o, bus.data_o};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got dec/rom/ram/we=%b%b%b%b ra=%h dev=%h rdy=%b data=%h, want %b%b%b%b ra=%h dev=%h rdy=%b data=%h",
                 nm, got.dec, got.rom, got.ram, got.ram_we, got.ra, got.dev, got.rdy, got.dat,
                 want.dec, want.rom, want.ram, want.ram_we, want.ra, want.dev, want.rdy, want.dat);
      end
    end else if (drain && !drain_done) begin
      drain_done = 1'b1;
      checks++;
      if (name_q.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d pending, want 0", name_q.size());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cyc_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = 16'h0000;
    bus.data_i = 8'h00;

    add(0, 0, 16'h0000, 8'h00, ex(DEC, 17'h00000, 16'h0, 1, 8'h00));
    for (int k = 0; k < 8; k++)
      add(1, 0, 16'h0010 + 16'(k), 8'h00, ex(DEC, 17'h00010 + 17'(k), 16'h0, 1, 8'(k)));
    add(1, 0, 16'h2345, 8'h00, ex(RAM,  17'h02345, 16'h0, 1, 8'h00));
    add(1, 1, 16'h0011, 8'h0B, ex(DEC,  17'h00011, 16'h0, 1, 8'h01));
    add(1, 0, 16'h2345, 8'h00, ex(RAM,  17'h16345, 16'h0, 1, 8'h00));
    add(1, 0, 16'h0011, 8'h00, ex(DEC,  17'h00011, 16'h0, 1, 8'h0B));
    add(1, 0, 16'hE000, 8'h00, ex(ROM,  17'h0E000, 16'h0, 1, 8'h00));
    add(1, 0, 16'hFFFF, 8'h00, ex(ROM,  17'h0FFFF, 16'h0, 1, 8'h00));
    add(1, 1, 16'h0002, 8'h01, ex(DEC,  17'h00002, 16'h0, 1, 8'h00));
    add(1, 0, 16'hFFFF, 8'h00, ex(RAM,  17'h0FFFF, 16'h0, 1, 8'h00));
    add(1, 0, 16'h0002, 8'h00, ex(DEC,  17'h00002, 16'h0, 1, 8'h01));
    add(1, 1, 16'h0002, 8'h00, ex(DEC,  17'h00002, 16'h0, 1, 8'h01));
    add(1, 0, 16'hDFFF, 8'h00, ex(RAM,  17'h0DFFF, 16'h0, 1, 8'h00));
    add(0, 1, 16'h0012, 8'h09, ex(DEC,  17'h00012, 16'h0, 1, 8'h02));
    add(1, 0, 16'h0012, 8'h00, ex(DEC,  17'h00012, 16'h0, 1, 8'h02));
    add(1, 1, 16'h0000, 8'h05, ex(DEC,  17'h00000, 16'h0, 1, 8'h00));
    add(1, 0, 16'hFE10, 8'h00, ex(DEV,  17'h0FE10, 16'h0020, 1, 8'h00));
    add(1, 1, 16'hFE10, 8'h55, ex(DEV,  17'h0FE10, 16'h0020, 1, 8'h00));
    add(1, 0, 16'h0000, 8'h00, ex(DEC,  17'h00000, 16'h0, 1, 8'h05));
    add(1, 1, 16'h0000, 8'h20, ex(DEC,  17'h00000, 16'h0, 1, 8'h05));
    add(1, 0, 16'hFE10, 8'h00, ex(RAM,  17'h0FE10, 16'h0, 1, 8'h00));
    add(1, 1, 16'h0000, 8'h0F, ex(DEC,  17'h00000, 16'h0, 1, 8'h20));
    add(1, 0, 16'hFE00, 8'h00, ex(DEV,  17'h0FE00, 16'h8000, 1, 8'h00));
    add(1, 1, 16'h0000, 8'h10, ex(DEC,  17'h00000, 16'h0, 1, 8'h0F));
    add(1, 0, 16'hFE00, 8'h00, ex(RAM,  17'h0FE00, 16'h0, 1, 8'h00));
    add(1, 1, 16'h0001, 8'hAA, ex(DEC,  17'h00001, 16'h0, 1, 8'h00));
    add(1, 0, 16'h0001, 8'h00, ex(DEC,  17'h00001, 16'h0, 1, 8'hAA));
    add(1, 1, 16'h0013, 8'hFF, ex(DEC,  17'h00013, 16'h0, 1, 8'h03));
    add(1, 0, 16'h0013, 8'h00, ex(DEC,  17'h00013, 16'h0, 1, 8'h0F));
    add(1, 0, 16'h6000, 8'h00, ex(RAM,  17'h1E000, 16'h0, 1, 8'h00));
    add(1, 1, 16'h4000, 8'h77, ex(RAMW, 17'h04000, 16'h0, 1, 8'h00));
    add(1, 1, 16'h0003, 8'h44, ex(RAMW, 17'h00003, 16'h0, 1, 8'h00));
    add(1, 0, 16'h0018, 8'h00, ex(RAM,  17'h00018, 16'h0, 1, 8'h00));
    add(1, 0, 16'h000F, 8'h00, ex(RAM,  17'h0000F, 16'h0, 1, 8'h00));
    add(1, 0, 16'hFDFF, 8'h00, ex(ROM,  17'h0FDFF, 16'h0, 1, 8'h00));
    add(1, 0, 16'hFF00, 8'h00, ex(ROM,  17'h0FF00, 16'h0, 1, 8'h00));
    add(1, 0, 16'h0000, 8'h00, ex(DEC,  17'h00000, 16'h0, 1, 8'h10));

    repeat (3) @(posedge clk);
    foreach (tbl[i])
      step(tbl[i].cyc, tbl[i].we, tbl[i].addr, tbl[i].data, 1'b0, tbl[i].e, $sformatf("vec%0d", i));

    // Waited device 3: two-clock stall, second strobe inside the stall ignored
    step(1, 1, 16'h0000, 8'h03, 0, ex(DEC, 17'h00000, 16'h0, 1, 8'h10), "set_io3");
    step(1, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 0, 8'h00), "stall1_a");
    step(1, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 0, 8'h00), "stall1_b");
    step(0, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 1, 8'h00), "stall1_end");

    // Back-to-back waited cycles each stall
    step(1, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 0, 8'h00), "b2b_1a");
    step(0, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 0, 8'h00), "b2b_1b");
    step(1, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 0, 8'h00), "b2b_2a");
    step(0, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 0, 8'h00), "b2b_2b");
    step(0, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 1, 8'h00), "b2b_end");

    // Reset asserted in the WAIT clock
    step(1, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0008, 0, 8'h00), "rst_a");
    step(0, 0, 16'hFE00, 8'h00, 1, ex(DEV, 17'h0FE00, 16'h0008, 0, 8'h00), "rst_in_wait");
    step(0, 0, 16'h0000, 8'h00, 0, ex(DEC, 17'h00000, 16'h0, 1, 8'h00), "rst_io_l");
    step(1, 0, 16'h0011, 8'h00, 0, ex(DEC, 17'h00011, 16'h0, 1, 8'h01), "rst_bank1");
    step(1, 0, 16'h6000, 8'h00, 0, ex(RAM, 17'h06000, 16'h0, 1, 8'h00), "rst_bank3");
    step(1, 0, 16'hFE00, 8'h00, 0, ex(DEV, 17'h0FE00, 16'h0001, 1, 8'h00), "rst_dev0");

    @(posedge clk);
    #1;
    bus.cyc_i = 1'b0;
    drain = 1'b1;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
